morv_mem_ctrl: RTL
==================

// Module: morv_mem_ctrl
// PURPOSE
//  Memory controller directly downstream of the morv core's memory port.
//  Accepts one word/byte-strobed request at a time, drives a synchronous
//  single-port SRAM macro with configurable wait states, and returns read
//  data with a one-cycle ready pulse. Flags misaligned/out-of-range accesses
//  with an error response instead of touching the SRAM.
// PARAMETERS
//  ADDR_WIDTH   12        SRAM word-address width (2**ADDR_WIDTH words)
//  BASE_ADDR    32'h0     byte address of SRAM word 0; must be 4-byte aligned
//  WAIT_STATES  0         extra SRAM read latency cycles beyond 1 (0..15)
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           async active-low reset
//  core_valid   in   1           request present; held with fields until core_ready
//  core_addr    in   32          byte address
//  core_wdata   in   32          write data
//  core_write   in   1           1=write, 0=read
//  core_wstrb   in   4           byte enables for writes
//  core_rdata   out  32          read data, valid while core_ready=1
//  core_ready   out  1           one-cycle completion pulse
//  core_err     out  1           with core_ready: request rejected
//  mem_en       out  1           SRAM access strobe
//  mem_we       out  4           SRAM byte write enables (0 = read)
//  mem_addr     out  ADDR_WIDTH  SRAM word address
//  mem_wdata    out  32          SRAM write data
//  mem_rdata    in   32          SRAM read data, valid WAIT_STATES+1 cycles after mem_en
// BEHAVIOUR
//  - Clocking: one clock, clk. Reset: asynchronous, active-low, rst_n.
//  - Reset (async): state=IDLE; core_ready/core_err/mem_en=0, mem_we=0,
//    core_rdata/mem_addr/mem_wdata=0, wait counter=0. Mid-access reset aborts
//    immediately; mem_en drops without waiting for a clock edge; no response.
//  - FSM: IDLE, ACCESS, WAIT, RESP. Only IDLE samples core_valid.
//  - IDLE: core_valid=1 -> capture addr/wdata/write/wstrb. Error if addr[1:0]!=0
//    or (addr-BASE_ADDR) >= 4*2**ADDR_WIDTH (32-bit unsigned compare; below-base
//    wraps high and is rejected). Error -> RESP with err, rdata_q=0, no mem_en.
//    Else -> ACCESS.
//  - ACCESS (1 cycle): mem_en=1, mem_addr=(addr-BASE_ADDR)>>2, mem_wdata=wdata,
//    mem_we=write?wstrb:4'b0. -> WAIT with counter=WAIT_STATES.
//  - WAIT (WAIT_STATES+1 cycles): mem_en=0. When counter=0: read loads rdata_q
//    from mem_rdata; write leaves rdata_q unchanged. -> RESP. Else counter-1.
//  - RESP (1 cycle): core_ready=1, core_err per request, core_rdata=rdata_q.
//    -> IDLE. Next request accepted no earlier than the cycle after RESP.
//  - Latency: accept cycle I -> core_ready in I+3+WAIT_STATES. Error: I+1.
//  - core_rdata holds its last value outside RESP. Writes return the previous
//    rdata_q; the core must ignore it.
//  - core_valid dropping before ready: the transaction still completes.
//  - Write with wstrb=0: mem_en pulses with mem_we=0; normal completion.
//  - Counter width: max(1,$clog2(WAIT_STATES+1)); no wrap, loaded only in ACCESS.
//  - mem_addr/mem_wdata/mem_we are registered and change only on ACCESS entry.
//    mem_en is decoded from the state register.
// STRUCTURE
//  - rv32_pkg gains mem_ctrl_state_t (IDLE/ACCESS/WAIT/RESP) and
//    MEM_RESP_ERR/MEM_RESP_OK constants.
//  - One natural sub-module: morv_addr_decode (combinational range/alignment
//    check -> err, word index), reused by future peripheral decoders.
// TESTING
//  - WAIT_STATES=0: write 0xDEADBEEF to 0x10, wstrb=F, then read 0x10 ->
//    ready 3 cycles after each accept, mem_addr=4, rdata=0xDEADBEEF, err=0.
//  - Byte strobes: after the above, write 0x000000AA with wstrb=0001 to 0x10,
//    then read -> 0xDEADBEAA.
//  - WAIT_STATES=3: read -> mem_en 1 cycle, ready at I+6, exactly one cycle.
//  - Errors: read 0x12 (misaligned) and 0x4000 (ADDR_WIDTH=12) -> ready at
//    I+1, err=1, rdata=0, mem_en never asserted.
//  - BASE_ADDR=0x8000_0000: read 0x7FFF_FFFC -> err=1; read 0x8000_0004 ->
//    mem_addr=1.
//  - Assert rst_n=0 during WAIT -> outputs zero with no clock edge; no ready
//    pulse; next request after reset completes normally.

Source files
------------

// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
//   Shared types and constants for the morv core and its memory-side blocks.
//   Contents:
//     mem_ctrl_state_t  - memory controller FSM state encoding
//     MEM_RESP_OK/ERR   - value of the error flag carried with a response
// ---------------------------------------------------------------------------
package rv32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } mem_ctrl_state_t;

    localparam logic MEM_RESP_OK  = 1'b0;
    localparam logic MEM_RESP_ERR = 1'b1;

endpackage

// File: rtl/morv_addr_decode.sv
// ---------------------------------------------------------------------------
// morv_addr_decode
//   Combinational alignment/range check for a word-addressed target placed
//   at BASE_ADDR and spanning 2**ADDR_WIDTH 32-bit words.
//   Ports:
//     addr      in  32          byte address from the core
//     err       out 1           misaligned or outside the target window
//     word_idx  out ADDR_WIDTH  word index inside the window
// ---------------------------------------------------------------------------
module morv_addr_decode #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic [31:0]           addr,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] word_idx
);

    // Window size in bytes; 33 bits so ADDR_WIDTH=30 still fits.
    localparam logic [32:0] RANGE_BYTES = 33'd4 << ADDR_WIDTH;

    logic [31:0] offset;

    // Unsigned subtraction: addresses below the base wrap to huge offsets
    // and therefore fail the range compare.
    assign offset   = addr - BASE_ADDR;
    assign err      = (addr[1:0] != 2'b00) || ({1'b0, offset} >= RANGE_BYTES);
    assign word_idx = offset[ADDR_WIDTH+1:2];

endmodule

// File: rtl/morv_mem_ctrl.sv
// ---------------------------------------------------------------------------
// morv_mem_ctrl
//   Single-outstanding-request bridge from the morv core memory port to a
//   synchronous single-port SRAM with WAIT_STATES extra read latency.
//   Bad addresses are answered with an error response without an SRAM access.
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     core_valid/addr/wdata/write/wstrb  request (sampled only in IDLE)
//     core_rdata/ready/err              response (ready is a 1-cycle pulse)
//     mem_en/we/addr/wdata              SRAM command
//     mem_rdata                         SRAM read data
// ---------------------------------------------------------------------------
module morv_mem_ctrl #(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_valid,
    input  logic [31:0]           core_addr,
    input  logic [31:0]           core_wdata,
    input  logic                  core_write,
    input  logic [3:0]            core_wstrb,
    output logic [31:0]           core_rdata,
    output logic                  core_ready,
    output logic                  core_err,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    import rv32_pkg::*;

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    mem_ctrl_state_t       state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  err_reg;
    logic                  write_reg;
    logic [31:0]           rdata_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [3:0]            mem_we_reg;
    logic [31:0]           mem_wdata_reg;

    logic                  dec_err;
    logic [ADDR_WIDTH-1:0] dec_idx;
    logic                  accept;

    morv_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_addr_decode (
        .addr     (core_addr),
        .err      (dec_err),
        .word_idx (dec_idx)
    );

    assign accept = (state_reg == ST_IDLE) && core_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (core_valid) state_next = dec_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS: state_next = ST_WAIT;
            ST_WAIT:   if (cnt_reg == '0) state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            err_reg       <= MEM_RESP_OK;
            write_reg     <= 1'b0;
            rdata_reg     <= '0;
            mem_addr_reg  <= '0;
            mem_we_reg    <= '0;
            mem_wdata_reg <= '0;
        end else begin
            if (accept) begin
                err_reg   <= dec_err ? MEM_RESP_ERR : MEM_RESP_OK;
                write_reg <= core_write;
                if (dec_err) begin
                    rdata_reg <= '0;
                end else begin
                    // SRAM command is registered on the way into ACCESS so the
                    // macro sees stable inputs for the whole strobe cycle.
                    mem_addr_reg  <= dec_idx;
                    mem_wdata_reg <= core_wdata;
                    mem_we_reg    <= core_write ? core_wstrb : 4'b0000;
                end
            end
            if (state_reg == ST_ACCESS) begin
                cnt_reg <= CNT_W'(WAIT_STATES);
            end
            if (state_reg == ST_WAIT) begin
                if (cnt_reg == '0) begin
                    // Writes keep the old read data; the core ignores it.
                    if (!write_reg) rdata_reg <= mem_rdata;
                end else begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end
    end

    // mem_en comes straight from the state register so an async reset drops
    // it immediately, mid-access included.
    assign mem_en     = (state_reg == ST_ACCESS);
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign core_ready = (state_reg == ST_RESP);
    assign core_err   = (state_reg == ST_RESP) && (err_reg == MEM_RESP_ERR);
    assign core_rdata = rdata_reg;

endmodule
